// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : seven_seg_scanner
//  Purpose  : Multiplexed 4-digit seven-segment driver with frame snapshot
//             and leading-zero blanking.
//  Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       blank_lz,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hund,
    input  logic [3:0] thou,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int unsigned      CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [3:0]       AN_OFF   = 4'b1111;
    localparam logic [6:0]       SEG_OFF  = 7'h7F;
    localparam logic [6:0]       SEG_DASH = 7'h3F;

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       snap_ones_q, snap_tens_q, snap_hund_q, snap_thou_q;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic             tick;
    logic             wrap;
    logic             load;
    logic             blank_thou, blank_hund, blank_tens;
    logic [3:0]       digit;
    logic             digit_blank;
    logic [3:0]       an_sel;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    assign tick = (presc_q == CNT_LAST);
    assign wrap = tick && (idx_q == 2'd3);

    // Blanking cascades from the most significant digit down; ones always shows.
    assign blank_thou = blank_lz && (snap_thou_q == 4'd0);
    assign blank_hund = blank_thou && (snap_hund_q == 4'd0);
    assign blank_tens = blank_hund && (snap_tens_q == 4'd0);

    always_comb begin
        digit       = snap_ones_q;
        digit_blank = 1'b0;
        an_sel      = 4'b1110;
        case (idx_q)
            2'd0: begin
                digit       = snap_ones_q;
                digit_blank = 1'b0;
                an_sel      = 4'b1110;
            end
            2'd1: begin
                digit       = snap_tens_q;
                digit_blank = blank_tens;
                an_sel      = 4'b1101;
            end
            2'd2: begin
                digit       = snap_hund_q;
                digit_blank = blank_hund;
                an_sel      = 4'b1011;
            end
            default: begin
                digit       = snap_thou_q;
                digit_blank = blank_thou;
                an_sel      = 4'b0111;
            end
        endcase
    end

    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        load    = 1'b0;
        an_d    = AN_OFF;
        seg_d   = SEG_OFF;
        if (!en) begin
            // Disabled: track the inputs continuously so enabling shows fresh data.
            presc_d = '0;
            idx_d   = 2'd0;
            load    = 1'b1;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            idx_d   = tick ? idx_q + 2'd1 : idx_q;
            load    = wrap;
            an_d    = digit_blank ? AN_OFF  : an_sel;
            seg_d   = digit_blank ? SEG_OFF : decode(digit);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            idx_q       <= 2'd0;
            snap_ones_q <= 4'd0;
            snap_tens_q <= 4'd0;
            snap_hund_q <= 4'd0;
            snap_thou_q <= 4'd0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            if (load) begin
                snap_ones_q <= ones;
                snap_tens_q <= tens;
                snap_hund_q <= hund;
                snap_thou_q <= thou;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = en && wrap;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seven_seg_scanner
//  Purpose  : Directed self-checking bench for seven_seg_scanner (REFRESH_DIV=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scanner;

    localparam int unsigned REFRESH_DIV = 4;

    logic       clk;
    logic       reset;
    logic       en;
    logic       blank_lz;
    logic [3:0] ones, tens, hund, thou;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame_tick;

    int tests_run;
    int tests_failed;

    seven_seg_scanner #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .blank_lz   (blank_lz),
        .ones       (ones),
        .tens       (tens),
        .hund       (hund),
        .thou       (thou),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected an/seg packed per slot: {slot3, slot2, slot1, slot0}.
    typedef struct packed {
        logic [3:0]  ones;
        logic [3:0]  tens;
        logic [3:0]  hund;
        logic [3:0]  thou;
        logic        blz;
        logic [15:0] exp_an;
        logic [27:0] exp_seg;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b0; en = 1'b0; blank_lz = 1'b0;
        ones = 4'd0; tens = 4'd0; hund = 4'd0; thou = 4'd0;

        vecs[0] = '{4'h1, 4'h2, 4'h3, 4'h4, 1'b0, 16'h7BDE, {7'h19, 7'h30, 7'h24, 7'h79}};
        vecs[1] = '{4'h0, 4'h5, 4'h0, 4'h0, 1'b1, 16'hFFDE, {7'h7F, 7'h7F, 7'h12, 7'h40}};
        vecs[2] = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{4'hB, 4'h0, 4'h0, 4'h0, 1'b0, 16'h7BDE, {7'h40, 7'h40, 7'h40, 7'h3F}};
        vecs[4] = '{4'h9, 4'h0, 4'h7, 4'h0, 1'b1, 16'hFBDE, {7'h7F, 7'h78, 7'h40, 7'h10}};
        vecs[5] = '{4'h8, 4'h0, 4'h0, 4'hA, 1'b1, 16'h7BDE, {7'h3F, 7'h40, 7'h40, 7'h00}};

        #1 reset = 1'b1;
        #2;
        chk("reset_an", an, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_ft", frame_tick, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            en = 1'b0;
            ones = vecs[i].ones; tens = vecs[i].tens;
            hund = vecs[i].hund; thou = vecs[i].thou;
            blank_lz = vecs[i].blz;
            wait_edges(2);
            chk($sformatf("v%0d_dis_an", i), an, 4'hF);
            chk($sformatf("v%0d_dis_seg", i), seg, 7'h7F);
            @(negedge clk) en = 1'b1;
            wait_edges(2);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("v%0d_s%0d_an", i, k), an, vecs[i].exp_an[k*4 +: 4]);
                chk($sformatf("v%0d_s%0d_seg", i, k), seg, vecs[i].exp_seg[k*7 +: 7]);
                wait_edges(4);
            end
        end

        // Scan order, frame_tick cadence and snapshot stability.
        @(negedge clk);
        en = 1'b0; blank_lz = 1'b0;
        ones = 4'd1; tens = 4'd2; hund = 4'd3; thou = 4'd4;
        wait_edges(2);
        @(negedge clk) en = 1'b1;
        for (int n = 0; n < 42; n++) begin
            wait_edges(1);
            chk($sformatf("scan_ft_%0d", n), frame_tick, (n == 14 || n == 30));
            if (n == 1)  begin chk("scan_s0_an", an, 4'hE); chk("scan_s0_seg", seg, 7'h79); end
            if (n == 5)  begin chk("scan_s1_an", an, 4'hD); chk("scan_s1_seg", seg, 7'h24); tens = 4'd7; end
            if (n == 6)  chk("stable_tens_seg", seg, 7'h24);
            if (n == 9)  begin chk("scan_s2_an", an, 4'hB); chk("scan_s2_seg", seg, 7'h30); end
            if (n == 13) begin chk("scan_s3_an", an, 4'h7); chk("scan_s3_seg", seg, 7'h19); end
            if (n == 21) begin chk("new_tens_an", an, 4'hD); chk("new_tens_seg", seg, 7'h78); end
            if (n == 41) begin chk("pre_rst_an", an, 4'hB); chk("pre_rst_seg", seg, 7'h30); end
        end

        // Reset between clock edges while slot 2 is displayed.
        #2 reset = 1'b1;
        #1;
        chk("midrst_an", an, 4'hF);
        chk("midrst_seg", seg, 7'h7F);
        chk("midrst_ft", frame_tick, 1'b0);
        @(negedge clk) reset = 1'b0;
        for (int m = 0; m < 22; m++) begin
            wait_edges(1);
            chk($sformatf("post_ft_%0d", m), frame_tick, (m == 14));
            if (m == 1)  begin chk("post_s0_an", an, 4'hE); chk("post_s0_seg", seg, 7'h40); end
            if (m == 5)  begin chk("post_s1_an", an, 4'hD); chk("post_s1_seg", seg, 7'h40); end
            if (m == 21) begin chk("post_load_an", an, 4'hD); chk("post_load_seg", seg, 7'h78); end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
